// File: rtl/lsu_bus_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the data-RAM bus.
// The load/store unit takes the master view; the pipeline and RAM side
// (or a testbench standing in for them) takes the slave view.
interface lsu_bus_ctrl_if #(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
);
  // Pipeline request side
  logic                 req_valid;
  logic                 req_we;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;

  // Pipeline response side
  logic                 stall;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 misalign;

  // Data RAM bus
  logic                 bus_req_valid;
  logic                 bus_req_ready;
  logic [XLEN-1:0]      bus_addr;
  logic                 bus_we;
  logic [XLEN-1:0]      bus_wdata;
  logic [BUS_BYTES-1:0] bus_wstrb;
  logic                 bus_resp_valid;
  logic [XLEN-1:0]      bus_resp_data;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output stall, resp_valid, resp_rdata, misalign,
    output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  stall, resp_valid, resp_rdata, misalign,
    input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit between the MEM stage and a valid/ready data bus.
// One request per instruction: stores are lane-shifted with byte strobes,
// loads are extracted from the aligned doubleword and sign/zero-extended.
// Misaligned accesses never reach the bus and complete with misalign=1.
// The pipeline is held via a combinational stall until the DONE cycle.
module lsu_bus_ctrl #(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
) (
  input logic            sys_clk,
  input logic            sys_rst,
  lsu_bus_ctrl_if.master lsu_io
);

  localparam int OFF_W = $clog2(BUS_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q;

  // Latched request fields needed after the request has been accepted
  logic [OFF_W-1:0]     latOff_q;
  logic [1:0]           latSize_q;
  logic                 latUnsigned_q;

  // Registered bus outputs, which double as the latched address/we/data
  logic                 busReqValid_q;
  logic                 busWe_q;
  logic [XLEN-1:0]      busAddr_q;
  logic [XLEN-1:0]      busWdata_q;
  logic [BUS_BYTES-1:0] busWstrb_q;

  // Registered pipeline response
  logic                 respValid_q;
  logic                 misalign_q;
  logic [XLEN-1:0]      respRdata_q;

  // Values derived from the incoming request
  logic [OFF_W-1:0]     reqOff_d;
  logic                 misaligned_d;
  logic [BUS_BYTES-1:0] baseMask_d;
  logic [BUS_BYTES-1:0] wstrb_d;
  logic [XLEN-1:0]      wdata_d;

  // Values derived from the bus read data and latched request
  logic [XLEN-1:0]      shifted_d;
  logic                 signFill_d;
  logic [XLEN-1:0]      loadData_d;

  // Decode the incoming request: alignment check, byte strobes, lane-shifted store data
  always_comb begin
    reqOff_d     = lsu_io.req_addr[OFF_W-1:0];
    misaligned_d = 1'b0;
    baseMask_d   = '0;
    case (lsu_io.req_size)
      2'd0: begin
        misaligned_d = 1'b0;
        baseMask_d   = BUS_BYTES'(8'h01);
      end
      2'd1: begin
        misaligned_d = lsu_io.req_addr[0];
        baseMask_d   = BUS_BYTES'(8'h03);
      end
      2'd2: begin
        misaligned_d = |lsu_io.req_addr[1:0];
        baseMask_d   = BUS_BYTES'(8'h0F);
      end
      default: begin
        misaligned_d = |lsu_io.req_addr[2:0];
        baseMask_d   = '1;
      end
    endcase
    wstrb_d = lsu_io.req_we ? (baseMask_d << reqOff_d) : '0;
    wdata_d = lsu_io.req_wdata << {reqOff_d, 3'b000};
  end

  // Extract the addressed bytes from the read doubleword and extend them to XLEN
  always_comb begin
    shifted_d  = lsu_io.bus_resp_data >> {latOff_q, 3'b000};
    signFill_d = 1'b0;
    loadData_d = shifted_d;
    case (latSize_q)
      2'd0: begin
        signFill_d = shifted_d[7] & ~latUnsigned_q;
        loadData_d = {{(XLEN-8){signFill_d}}, shifted_d[7:0]};
      end
      2'd1: begin
        signFill_d = shifted_d[15] & ~latUnsigned_q;
        loadData_d = {{(XLEN-16){signFill_d}}, shifted_d[15:0]};
      end
      2'd2: begin
        signFill_d = shifted_d[31] & ~latUnsigned_q;
        loadData_d = {{(XLEN-32){signFill_d}}, shifted_d[31:0]};
      end
      default: begin
        signFill_d = 1'b0;
        loadData_d = shifted_d;
      end
    endcase
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      latOff_q      <= '0;
      latSize_q     <= '0;
      latUnsigned_q <= 1'b0;
      busReqValid_q <= 1'b0;
      busWe_q       <= 1'b0;
      busAddr_q     <= '0;
      busWdata_q    <= '0;
      busWstrb_q    <= '0;
      respValid_q   <= 1'b0;
      misalign_q    <= 1'b0;
      respRdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          respValid_q <= 1'b0;
          misalign_q  <= 1'b0;
          if (lsu_io.req_valid) begin
            if (misaligned_d) begin
              state_q     <= DONE;
              respValid_q <= 1'b1;
              misalign_q  <= 1'b1;
              respRdata_q <= '0;
            end else begin
              state_q       <= REQ;
              latOff_q      <= reqOff_d;
              latSize_q     <= lsu_io.req_size;
              latUnsigned_q <= lsu_io.req_unsigned;
              busReqValid_q <= 1'b1;
              busWe_q       <= lsu_io.req_we;
              busAddr_q     <= {lsu_io.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              busWdata_q    <= wdata_d;
              busWstrb_q    <= wstrb_d;
            end
          end
        end
        REQ: begin
          if (lsu_io.bus_req_ready) begin
            busReqValid_q <= 1'b0;
            if (busWe_q) begin
              state_q     <= DONE;
              respValid_q <= 1'b1;
              misalign_q  <= 1'b0;
              respRdata_q <= '0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lsu_io.bus_resp_valid) begin
            state_q     <= DONE;
            respValid_q <= 1'b1;
            misalign_q  <= 1'b0;
            respRdata_q <= loadData_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
          misalign_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface from the registered state; stall releases in DONE
  always_comb begin
    lsu_io.stall         = lsu_io.req_valid && (state_q != DONE);
    lsu_io.resp_valid    = respValid_q;
    lsu_io.resp_rdata    = respRdata_q;
    lsu_io.misalign      = misalign_q;
    lsu_io.bus_req_valid = busReqValid_q;
    lsu_io.bus_addr      = busAddr_q;
    lsu_io.bus_we        = busWe_q;
    lsu_io.bus_wdata     = busWdata_q;
    lsu_io.bus_wstrb     = busWstrb_q;
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl. Expected responses are queued when a
// request is driven and popped by a monitor whenever resp_valid pulses; bus
// outputs, stall and latency are checked cycle by cycle while the request runs.
module tb_lsu_bus_ctrl;

  logic clock;
  logic reset;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
  } expT;

  expT expQ[$];
  int  vectorCount     = 0;
  int  miscompareCount = 0;
  logic prevRespValid  = 1'b0;

  lsu_bus_ctrl_if #(.XLEN(64), .BUS_BYTES(8)) lsuIf ();

  lsu_bus_ctrl #(.XLEN(64), .BUS_BYTES(8)) dut (
    .sys_clk (clock),
    .sys_rst (reset),
    .lsu_io  (lsuIf)
  );

  // Free-running pipeline clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Overall safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (lsuIf.resp_valid) begin
      checkOutput("respSinglePulse", 64'(prevRespValid), 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResp", 64'd1, 64'd0);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("respRdata", lsuIf.resp_rdata, e.rdata);
        checkOutput("respMisalign", 64'(lsuIf.misalign), 64'(e.mis));
      end
    end
    prevRespValid = lsuIf.resp_valid;
  end

  // Drive one request and act as the RAM until the DONE cycle is observed.
  // Returns at the negedge of the DONE cycle with req_valid still high, so a
  // following call presents the next request in the cycle after DONE.
  task automatic applyStimulus(input string name, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [1:0] size,
                               input logic uns, input int readyDelay, input int respDelay,
                               input logic junkResp, input logic [63:0] memData,
                               input logic [63:0] expRdata, input logic expMis,
                               input logic [63:0] expBusAddr, input logic [7:0] expWstrb,
                               input logic [63:0] expWdata);
    int cycle;
    int reqCycles;
    int waitCycles;
    int expLatency;
    int expReqCycles;
    logic handshook;
    logic done;
    logic [63:0] laneMask;
    expT e;

    for (int b = 0; b < 8; b++) laneMask[b*8 +: 8] = {8{expWstrb[b]}};
    expLatency   = expMis ? 1 : (2 + readyDelay + (we ? 0 : respDelay + 1));
    expReqCycles = expMis ? 0 : readyDelay + 1;
    e.rdata = expRdata;
    e.mis   = expMis;
    expQ.push_back(e);

    @(posedge clock);
    #1;
    lsuIf.req_valid      = 1'b1;
    lsuIf.req_we         = we;
    lsuIf.req_addr       = addr;
    lsuIf.req_wdata      = wdata;
    lsuIf.req_size       = size;
    lsuIf.req_unsigned   = uns;
    lsuIf.bus_req_ready  = 1'b0;
    lsuIf.bus_resp_valid = 1'b0;

    cycle      = 0;
    reqCycles  = 0;
    waitCycles = 0;
    handshook  = 1'b0;
    done       = 1'b0;
    while (!done && cycle < 40) begin
      @(negedge clock);
      checkOutput({name, ".stall"}, 64'(lsuIf.stall), 64'(!lsuIf.resp_valid));
      if (lsuIf.resp_valid) begin
        done = 1'b1;
        checkOutput({name, ".latency"}, 64'(cycle), 64'(expLatency));
        checkOutput({name, ".busReqCycles"}, 64'(reqCycles), 64'(expReqCycles));
        lsuIf.bus_req_ready  = 1'b0;
        lsuIf.bus_resp_valid = 1'b0;
      end else begin
        lsuIf.bus_req_ready  = 1'b0;
        lsuIf.bus_resp_valid = 1'b0;
        if (lsuIf.bus_req_valid) begin
          reqCycles++;
          checkOutput({name, ".busAddr"}, lsuIf.bus_addr, expBusAddr);
          checkOutput({name, ".busWe"}, 64'(lsuIf.bus_we), 64'(we));
          checkOutput({name, ".busWstrb"}, 64'(lsuIf.bus_wstrb), 64'(expWstrb));
          checkOutput({name, ".busWdata"}, lsuIf.bus_wdata & laneMask, expWdata & laneMask);
          if (reqCycles > readyDelay) begin
            lsuIf.bus_req_ready = 1'b1;
            handshook = 1'b1;
          end else if (junkResp) begin
            lsuIf.bus_resp_valid = 1'b1;
            lsuIf.bus_resp_data  = ~memData;
          end
        end else if (handshook && !we) begin
          waitCycles++;
          if (waitCycles > respDelay) begin
            lsuIf.bus_resp_valid = 1'b1;
            lsuIf.bus_resp_data  = memData;
          end
        end
        @(posedge clock);
        #1;
        cycle++;
      end
    end
    if (!done) checkOutput({name, ".timeout"}, 64'd0, 64'd1);
  endtask

  // Drop the request and let the unit sit idle for a few cycles
  task automatic idleCycles(input int n);
    @(posedge clock);
    #1;
    lsuIf.req_valid      = 1'b0;
    lsuIf.bus_req_ready  = 1'b0;
    lsuIf.bus_resp_valid = 1'b0;
    repeat (n) @(posedge clock);
  endtask

  // Check every registered output is back at its cleared value
  task automatic checkCleared(input string name, input logic expStall);
    checkOutput({name, ".respValid"}, 64'(lsuIf.resp_valid), 64'd0);
    checkOutput({name, ".misalign"}, 64'(lsuIf.misalign), 64'd0);
    checkOutput({name, ".respRdata"}, lsuIf.resp_rdata, 64'd0);
    checkOutput({name, ".busReqValid"}, 64'(lsuIf.bus_req_valid), 64'd0);
    checkOutput({name, ".busAddr"}, lsuIf.bus_addr, 64'd0);
    checkOutput({name, ".busWe"}, 64'(lsuIf.bus_we), 64'd0);
    checkOutput({name, ".busWdata"}, lsuIf.bus_wdata, 64'd0);
    checkOutput({name, ".busWstrb"}, 64'(lsuIf.bus_wstrb), 64'd0);
    checkOutput({name, ".stall"}, 64'(lsuIf.stall), 64'(expStall));
  endtask

  // Abandon a load in WAIT with a reset, then present a stray read response
  task automatic resetInWait();
    @(posedge clock);
    #1;
    lsuIf.req_valid      = 1'b1;
    lsuIf.req_we         = 1'b0;
    lsuIf.req_addr       = 64'h48;
    lsuIf.req_wdata      = 64'hFFFF_FFFF_FFFF_FFFF;
    lsuIf.req_size       = 2'd3;
    lsuIf.req_unsigned   = 1'b0;
    lsuIf.bus_req_ready  = 1'b0;
    lsuIf.bus_resp_valid = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("rstWait.reqValid", 64'(lsuIf.bus_req_valid), 64'd1);
    lsuIf.bus_req_ready = 1'b1;
    @(posedge clock);
    #1;
    lsuIf.bus_req_ready = 1'b0;
    @(negedge clock);
    checkOutput("rstWait.inWaitReq", 64'(lsuIf.bus_req_valid), 64'd0);
    checkOutput("rstWait.inWaitStall", 64'(lsuIf.stall), 64'd1);
    @(posedge clock);
    #1;
    reset           = 1'b1;
    lsuIf.req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset                = 1'b0;
    lsuIf.bus_resp_valid = 1'b1;
    lsuIf.bus_resp_data  = 64'h5555_AAAA_5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkCleared("rstWait", 1'b0);
    end
    lsuIf.bus_resp_valid = 1'b0;
  endtask

  // Main sequence
  initial begin
    reset                = 1'b1;
    lsuIf.req_valid      = 1'b0;
    lsuIf.req_we         = 1'b0;
    lsuIf.req_addr       = '0;
    lsuIf.req_wdata      = '0;
    lsuIf.req_size       = '0;
    lsuIf.req_unsigned   = 1'b0;
    lsuIf.bus_req_ready  = 1'b0;
    lsuIf.bus_resp_valid = 1'b0;
    lsuIf.bus_resp_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkCleared("reset", 1'b0);

    $display("[TB] stores and loads with an immediately ready bus");
    applyStimulus("storeByte", 1'b1, 64'h8000_0005, 64'hAB, 2'd0, 1'b0, 0, 0, 1'b0, 64'd0,
                  64'd0, 1'b0, 64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000);
    idleCycles(2);
    applyStimulus("loadHalfS", 1'b0, 64'h102, 64'd0, 2'd1, 1'b0, 0, 0, 1'b0,
                  64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h100, 8'h00, 64'd0);
    idleCycles(1);
    applyStimulus("loadHalfU", 1'b0, 64'h102, 64'd0, 2'd1, 1'b1, 0, 0, 1'b0,
                  64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001, 1'b0, 64'h100, 8'h00, 64'd0);
    idleCycles(1);

    $display("[TB] backpressure with stray read valids during REQ");
    applyStimulus("backpress", 1'b0, 64'h204, 64'd0, 2'd2, 1'b0, 5, 2, 1'b1,
                  64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 64'h200, 8'h00, 64'd0);
    idleCycles(1);

    $display("[TB] misaligned accesses");
    applyStimulus("misWord", 1'b0, 64'h106, 64'd0, 2'd2, 1'b0, 0, 0, 1'b0, 64'd0,
                  64'd0, 1'b1, 64'd0, 8'h00, 64'd0);
    idleCycles(1);
    applyStimulus("misHalfSt", 1'b1, 64'h1, 64'h55, 2'd1, 1'b0, 0, 0, 1'b0, 64'd0,
                  64'd0, 1'b1, 64'd0, 8'h00, 64'd0);
    idleCycles(1);
    applyStimulus("misDouble", 1'b0, 64'h4, 64'd0, 2'd3, 1'b0, 0, 0, 1'b0, 64'd0,
                  64'd0, 1'b1, 64'd0, 8'h00, 64'd0);
    idleCycles(1);

    $display("[TB] back-to-back load then store");
    applyStimulus("b2bLoad", 1'b0, 64'h0, 64'd0, 2'd3, 1'b1, 0, 0, 1'b0,
                  64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 8'h00, 64'd0);
    applyStimulus("b2bStore", 1'b1, 64'h4, 64'hCAFE_F00D, 2'd2, 1'b0, 0, 0, 1'b0, 64'd0,
                  64'd0, 1'b0, 64'h0, 8'hF0, 64'hCAFE_F00D_0000_0000);
    idleCycles(1);

    $display("[TB] remaining sizes and lanes");
    applyStimulus("loadByteS", 1'b0, 64'h7, 64'd0, 2'd0, 1'b0, 0, 1, 1'b0,
                  64'h80AA_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 64'h0, 8'h00, 64'd0);
    idleCycles(1);
    applyStimulus("loadByteU", 1'b0, 64'h3, 64'd0, 2'd0, 1'b1, 0, 0, 1'b0,
                  64'h0000_0000_FF00_0000, 64'h0000_0000_0000_00FF, 1'b0, 64'h0, 8'h00, 64'd0);
    idleCycles(1);
    applyStimulus("storeHalf", 1'b1, 64'h16, 64'h1234, 2'd1, 1'b0, 1, 0, 1'b0, 64'd0,
                  64'd0, 1'b0, 64'h10, 8'hC0, 64'h1234_0000_0000_0000);
    idleCycles(1);
    applyStimulus("storeDbl", 1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 2, 0, 1'b0, 64'd0,
                  64'd0, 1'b0, 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF);
    idleCycles(1);
    applyStimulus("loadWordU", 1'b0, 64'h10C, 64'd0, 2'd2, 1'b1, 0, 0, 1'b0,
                  64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1'b0, 64'h108, 8'h00, 64'd0);
    idleCycles(1);

    $display("[TB] reset while waiting for read data");
    resetInWait();
    idleCycles(1);

    $display("[TB] recovery after reset");
    applyStimulus("recover", 1'b0, 64'h3E, 64'd0, 2'd1, 1'b0, 0, 0, 1'b0,
                  64'h7FFE_0000_0000_0000, 64'h0000_0000_0000_7FFE, 1'b0, 64'h38, 8'h00, 64'd0);
    idleCycles(3);

    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit between the MEM stage of the five-stage pipeline and a valid/ready data bus to the data RAM.
- Takes one load or store request per instruction from the MEM stage.
- Aligns stores onto 64-bit lanes with byte strobes, and extracts and sign/zero-extends load data.
- Stalls the pipeline until the bus transaction completes.
- Detects misaligned accesses and suppresses them.

Parameters:
XLEN, 64, data/address width (matches the pipeline `width).
BUS_BYTES, 8, bus data bytes; must equal XLEN/8.

Ports:
sys_clk  in  1  pipeline clock
sys_rst  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage has a load/store this cycle; held stable while stall=1
req_we  in  1  1=store, 0=load
req_addr  in  XLEN  byte address (ALU result)
req_wdata  in  XLEN  store data (rs2), LSB-aligned
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  zero-extend load result
stall  out  1  freeze IF..MEM pipeline registers
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores
misalign  out  1  valid with resp_valid; access was misaligned and suppressed
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_addr  out  XLEN  {req_addr[XLEN-1:3],3'b000}
bus_we  out  1  write request
bus_wdata  out  XLEN  lane-shifted store data
bus_wstrb  out  8  byte strobes
bus_resp_valid  in  1  read data valid (unused for writes)
bus_resp_data  in  XLEN  read data, full aligned doubleword

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Request fields are latched on the IDLE->REQ transition. All bus outputs are driven from the latched copies.
- Reset (sys_rst=1 on a rising edge):
  - state=IDLE; bus_req_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
  - resp_valid=0, resp_rdata=0, misalign=0, latches cleared.
  - Reset mid-transaction abandons it. A later bus_resp_valid seen in IDLE is ignored.
- IDLE transitions on req_valid:
  - aligned -> REQ.
  - misaligned -> DONE with misalign=1; no bus activity.
  - Misaligned means: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
- REQ: bus_req_valid=1 with addr/we/wdata/wstrb held stable until bus_req_ready=1. On the handshake edge: store -> DONE, load -> WAIT.
- WAIT: bus_req_valid=0. On bus_resp_valid=1, capture the extended data -> DONE.
- DONE: resp_valid=1 for exactly one cycle, resp_rdata valid this cycle, -> IDLE unconditionally. resp_rdata holds its value until the next DONE.
- stall = req_valid && (state!=DONE). stall is combinational, so the pipeline advances in the DONE cycle and the next request is seen in IDLE the following cycle.
- Minimum latency with ready=1 and response in the first WAIT cycle:
  - store: IDLE, REQ, DONE (3 cycles).
  - load: IDLE, REQ, WAIT, DONE (4 cycles).
- Store lanes (off = addr[2:0]):
  - bus_wstrb = base_mask << off, where base_mask = 0x01, 0x03, 0x0F, 0xFF for size 0..3.
  - bus_wdata = req_wdata << (8*off); lanes outside the strobe are don't-care but driven deterministically.
  - Loads drive bus_wstrb=0.
- Load extraction:
  - shifted = bus_resp_data >> (8*off); truncate to 8/16/32/64 bits.
  - Sign-extend from the top bit unless req_unsigned=1. Size 3 ignores req_unsigned.
- bus_resp_valid in IDLE, REQ or DONE is ignored. bus_req_ready outside REQ is ignored.
- req_valid dropping while in REQ/WAIT (protocol violation) does not abort the transaction; the FSM completes normally.

Test Plan:
- Store byte: addr=0x8000_0005, wdata=0xAB, size=0, ready=1 -> bus_addr=0x8000_0000, wstrb=0x20, wdata[47:40]=0xAB; resp_valid 2 cycles after req_valid asserted; stall high for 2 cycles.
- Load signed half: addr=0x102, size=1, resp_data=0x0000_0000_8001_0000 -> resp_rdata=0xFFFF_FFFF_FFFF_8001; with req_unsigned=1 -> 0x8001.
- Backpressure: bus_req_ready low 5 cycles, bus_resp_valid 3 cycles after handshake -> bus_req_valid and bus_addr stable throughout; stall continuous; single resp_valid pulse.
- Misaligned word: addr=0x106, size=2 -> no bus_req_valid ever; resp_valid and misalign=1 one cycle after request; resp_rdata=0.
- Back-to-back: load (double, addr=0x0, data=0x1122334455667788) then store word addr=0x4 -> rdata=0x1122334455667788; second request starts in IDLE the cycle after DONE with wstrb=0xF0.
- Reset in WAIT: sys_rst pulsed, then bus_resp_valid=1 -> state IDLE, resp_valid stays 0, all outputs 0.
